shiftrows: RTL and testbench

- AES ShiftRows / InvShiftRows stage for a 128-bit datapath.
- Cyclically rotates rows 1-3 of the 4x4 byte state matrix and registers the result.
- Sits between SubBytes and MixColumns in the round pipeline. The inverse mode serves the decryption path.

---
 rtl/shiftrows.sv | 67 ++++++
 tb/tb_shiftrows.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shiftrows.sv
// AES ShiftRows / InvShiftRows stage for a 128-bit datapath.
// This stage only moves bytes around. Row r of the column-major 4x4 state
// rotates left by r in forward mode, and right by r in inverse mode.
// Byte k is state[127-8k -: 8]. It sits at row k%4 and column k/4.
module shiftrows #(
  parameter bit REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic         in_valid,
  input  logic         inverse,
  output logic [127:0] out,
  output logic         out_valid
);

  logic [127:0] shifted;

  // Output byte (r,c) takes input byte (r,(c+r)%4) in forward mode.
  // In inverse mode it takes input byte (r,(c-r)%4).
  // Every output byte has exactly one source, so no byte is left undriven.
  function automatic logic [127:0] permute(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      int row;
      int col;
      int src;
      row = k % 4;
      col = k / 4;
      src = inv ? row + 4 * ((col - row + 4) % 4)
                : row + 4 * ((col + row) % 4);
      res[127 - 8*k -: 8] = s[127 - 8*src -: 8];
    end
    return res;
  endfunction

  // Combinational byte permutation, selected by the mode bit sampled with state.
  always_comb begin
    shifted = permute(state, inverse);
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [127:0] out_q;
      logic         valid_q;

      // The output register loads on every cycle. Downstream logic qualifies the data with out_valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          out_q   <= shifted;
          valid_q <= in_valid;
        end
      end

      assign out       = out_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign out       = shifted;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_shiftrows.sv
// Self-checking bench for shiftrows.
// The driver pushes one expected entry per cycle into a scoreboard queue.
// The monitor pops one entry per cycle and compares it with the DUT output.
module tb_shiftrows;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic         in_valid;
  logic         inverse;
  logic [127:0] out;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        nm;
    logic         v;
    logic         chk;
    logic         multi;
    logic [127:0] d;
    logic [127:0] src;
  } item_t;

  item_t q[$];

  int fwd_src [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  int inv_src [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  shiftrows #(.REGISTERED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .in_valid  (in_valid),
    .inverse   (inverse),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model built from the listed output byte orders.
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      src = inv ? inv_src[k] : fwd_src[k];
      r[127 - 8*k -: 8] = s[127 - 8*src -: 8];
    end
    return r;
  endfunction

  // Set the inputs for one cycle, push the expected output, then move past the next capture edge.
  task automatic cyc(input string nm, input logic r, input logic v, input logic inv,
                     input logic [127:0] st, input logic [127:0] exp_d,
                     input logic chk, input logic multi);
    item_t it;
    rst      = r;
    in_valid = v;
    inverse  = inv;
    state    = st;
    it.nm    = nm;
    it.v     = r ? 1'b0 : v;
    it.chk   = chk;
    it.multi = multi;
    it.d     = exp_d;
    it.src   = st;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: 3 time units after each capture edge, check the DUT output against the oldest expectation.
  initial begin
    item_t it;
    int    h [256];
    int    hbad;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() != 0) begin
        it = q.pop_front();
        total++;
        if (out_valid !== it.v) begin
          bad++;
          $display("FAIL %s valid: got %b want %b", it.nm, out_valid, it.v);
        end
        if (it.chk) begin
          total++;
          if (out !== it.d) begin
            bad++;
            $display("FAIL %s data: got %h want %h", it.nm, out, it.d);
          end
        end
        if (it.multi) begin
          for (int i = 0; i < 256; i++) h[i] = 0;
          for (int k = 0; k < 16; k++) begin
            h[it.src[127 - 8*k -: 8]]++;
            h[out[127 - 8*k -: 8]]--;
          end
          hbad = 0;
          for (int i = 0; i < 256; i++) if (h[i] != 0) hbad++;
          total++;
          if (hbad != 0) begin
            bad++;
            $display("FAIL %s multiset: got %h from %h want same bytes", it.nm, out, it.src);
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] seq  = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] sfwd = 128'h00050a0f04090e03080d02070c01060b;
    logic [127:0] sinv = 128'h000d0a0704010e0b0805020f0c090603;
    logic [127:0] fips = 128'hd42711aee0bf98f1b8b45de51e415230;
    logic [127:0] ffwd = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    logic [127:0] x;
    logic [127:0] y;
    int wait_cnt;

    // Hold reset while in_valid is high. Reset has priority, so the output must stay zero.
    cyc("rst0", 1'b1, 1'b1, 1'b0, 128'hdeadbeef_01234567_89abcdef_cafef00d, '0, 1'b1, 1'b0);
    cyc("rst1", 1'b1, 1'b1, 1'b1, 128'h11223344_55667788_99aabbcc_ddeeff00, '0, 1'b1, 1'b0);

    // Directed vectors. The first one after reset release must appear after exactly one cycle.
    cyc("fwd_seq",  1'b0, 1'b1, 1'b0, seq,  sfwd, 1'b1, 1'b0);
    cyc("inv_seq",  1'b0, 1'b1, 1'b1, seq,  sinv, 1'b1, 1'b0);
    cyc("fips_fwd", 1'b0, 1'b1, 1'b0, fips, ffwd, 1'b1, 1'b0);
    cyc("fips_inv", 1'b0, 1'b1, 1'b1, ffwd, fips, 1'b1, 1'b0);
    cyc("idle",     1'b0, 1'b0, 1'b0, fips, '0,   1'b0, 1'b0);

    // Streaming with alternating inverse and in_valid pattern 1,1,0,1.
    cyc("str0", 1'b0, 1'b1, 1'b0, seq,  sfwd, 1'b1, 1'b0);
    cyc("str1", 1'b0, 1'b1, 1'b1, seq,  sinv, 1'b1, 1'b0);
    cyc("str2", 1'b0, 1'b0, 1'b0, fips, '0,   1'b0, 1'b0);
    cyc("str3", 1'b0, 1'b1, 1'b1, ffwd, fips, 1'b1, 1'b0);

    // Assert reset mid-stream. The state in flight is discarded, then output resumes after release.
    cyc("mid_a",   1'b0, 1'b1, 1'b0, fips, ffwd, 1'b1, 1'b0);
    cyc("mid_rst", 1'b1, 1'b1, 1'b0, seq,  '0,   1'b1, 1'b0);
    cyc("mid_b",   1'b0, 1'b1, 1'b1, seq,  sinv, 1'b1, 1'b0);

    // Random states: check against the model, check that inverse then forward returns x, and check that no byte is lost or duplicated.
    for (int i = 0; i < 12; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model(x, 1'b1);
      cyc("rnd_fwd", 1'b0, 1'b1, 1'b0, x, model(x, 1'b0), 1'b1, 1'b1);
      cyc("rnd_inv", 1'b0, 1'b1, 1'b1, x, y,              1'b1, 1'b1);
      cyc("rnd_rt",  1'b0, 1'b1, 1'b0, y, x,              1'b1, 1'b1);
    end

    cyc("tail", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #4;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
